// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the bidirectional uio pad bus for three requesters, with a turnaround cycle between owners.
// Optional hold limit (forced release under contention) is built when ARB_HOLD_LIMIT_EN is defined.
module uio_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  dir,
  input  logic [23:0] wdata,
  input  logic [7:0]  uio_in,
  output logic [2:0]  gnt,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_e;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("uio_bus_arbiter: HOLD_MAX must be in 1..255");
  end

  state_e      state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  last_q, last_d;
  logic        wdir_q, wdir_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [7:0]  uio_out_q, uio_out_d;
  logic [7:0]  uio_oe_q, uio_oe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        busy_q, busy_d;

  logic [1:0]  pick;
  logic        any_req;
  logic        own_req;
  logic        force_rel;
  logic        arb;

  // Scan starts one past the previous winner, so the previous winner is scanned last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] p;
    p = 2'd0;
    case (l)
      2'd0:    p = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    p = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: p = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return p;
  endfunction

  function automatic logic [7:0] byte_of(input logic [23:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      default: return w[23:16];
    endcase
  endfunction

  assign pick    = rr_pick(req, last_q);
  assign any_req = |req;
  assign own_req = req[win_q];

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q, hold_d;
  logic [2:0] win_1h;

  assign win_1h    = 3'b001 << win_q;
  assign force_rel = (hold_q >= HOLD_LAST) && |(req & ~win_1h);
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    wdir_d    = wdir_q;
    uio_out_d = uio_out_q;
    rdata_d   = rdata_q;
    gnt_d     = 3'b000;
    uio_oe_d  = 8'h00;
    rvalid_d  = 1'b0;
    arb       = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
`endif

    case (state_q)
      S_IDLE: arb = any_req;
      S_TURN: begin
        if (own_req) begin
          state_d = S_OWN;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (!own_req || force_rel) begin
          if (any_req) arb = 1'b1;
          else         state_d = S_IDLE;
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arb) begin
      state_d = S_TURN;
      win_d   = pick;
      last_d  = pick;
      wdir_d  = dir[pick];
    end

    // Entering or staying in OWN never re-arbitrates, so win_q/wdir_q describe the owner here.
    if (state_d == S_OWN) begin
      gnt_d = 3'b001 << win_q;
      if (wdir_q) begin
        uio_oe_d  = 8'hFF;
        uio_out_d = byte_of(wdata, win_q);
      end else begin
        rdata_d  = uio_in;
        rvalid_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= 2'd0;
      last_q    <= 2'd2;
      wdir_q    <= 1'b0;
      gnt_q     <= 3'b000;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      wdir_q    <= wdir_d;
      gnt_q     <= gnt_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: reset, drive/read owners, round-robin order, abort and hold limit.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  dir;
  logic [23:0] wdata;
  logic [7:0]  uio_in;
  logic [2:0]  gnt;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  uio_bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .uio_in  (uio_in),
    .gnt     (gnt),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 3'b111;
    dir    = 3'b000;
    wdata  = 24'h000000;
    uio_in = 8'h00;

    // Reset with all requests asserted
    tick(); tick(); tick();
    chk("rst_gnt",     {5'b0, gnt}, 8'h00);
    chk("rst_oe",      uio_oe,      8'h00);
    chk("rst_out",     uio_out,     8'h00);
    chk("rst_rdata",   rdata,       8'h00);
    chk("rst_rvalid",  {7'b0, rvalid}, 8'h00);
    chk("rst_busy",    {7'b0, busy},   8'h00);

    // First grant after reset goes to requester 0, two edges after req is seen
    rst_n = 1'b1;
    tick();
    chk("first_turn_busy", {7'b0, busy}, 8'h01);
    chk("first_turn_gnt",  {5'b0, gnt},  8'h00);
    tick();
    chk("first_gnt",    {5'b0, gnt},    8'h01);
    chk("first_rvalid", {7'b0, rvalid}, 8'h01);
    req = 3'b000;
    tick();
    chk("first_rel_gnt",  {5'b0, gnt},  8'h00);
    chk("first_rel_busy", {7'b0, busy}, 8'h00);

    // Single drive owner (requester 1)
    req   = 3'b010;
    dir   = 3'b010;
    wdata = 24'h00A500;
    tick();
    chk("drv_turn_gnt", {5'b0, gnt}, 8'h00);
    chk("drv_turn_oe",  uio_oe,      8'h00);
    tick();
    chk("drv_gnt", {5'b0, gnt}, 8'h02);
    chk("drv_oe",  uio_oe,      8'hFF);
    chk("drv_out", uio_out,     8'hA5);
    wdata = 24'h003C00;
    tick();
    chk("drv_out_upd", uio_out, 8'h3C);
    dir = 3'b000;
    tick();
    chk("drv_dir_ignored", uio_oe, 8'hFF);
    req = 3'b000;
    tick();
    chk("drv_rel_gnt",  {5'b0, gnt},  8'h00);
    chk("drv_rel_oe",   uio_oe,       8'h00);
    chk("drv_rel_busy", {7'b0, busy}, 8'h00);
    chk("drv_rel_hold", uio_out,      8'h3C);

    // Read owner (requester 2)
    req    = 3'b100;
    dir    = 3'b000;
    uio_in = 8'h5A;
    tick();
    chk("rd_turn_rvalid", {7'b0, rvalid}, 8'h00);
    tick();
    chk("rd_gnt",    {5'b0, gnt},    8'h04);
    chk("rd_oe",     uio_oe,         8'h00);
    chk("rd_rdata",  rdata,          8'h5A);
    chk("rd_rvalid", {7'b0, rvalid}, 8'h01);
    uio_in = 8'hC3;
    tick();
    chk("rd_rdata2",  rdata,          8'hC3);
    chk("rd_rvalid2", {7'b0, rvalid}, 8'h01);
    req = 3'b000;
    tick();
    chk("rd_rel_rvalid", {7'b0, rvalid}, 8'h00);
    chk("rd_rel_rdata",  rdata,          8'hC3);
    chk("rd_rel_out",    uio_out,        8'h3C);

    // Round-robin with all three requesting: order 0, 1, 2, 0
    req   = 3'b111;
    dir   = 3'b111;
    wdata = 24'h332211;
    tick();
    chk("rr_turn0", {5'b0, gnt}, 8'h00);
    tick();
    chk("rr_gnt0",  {5'b0, gnt}, 8'h01);
    chk("rr_out0",  uio_out,     8'h11);
    tick();
    chk("rr_gnt0b", {5'b0, gnt}, 8'h01);
    req = 3'b110;
    tick();
    chk("rr_turn1_gnt", {5'b0, gnt}, 8'h00);
    chk("rr_turn1_oe",  uio_oe,      8'h00);
    tick();
    chk("rr_gnt1",  {5'b0, gnt}, 8'h02);
    chk("rr_out1",  uio_out,     8'h22);
    tick();
    chk("rr_gnt1b", {5'b0, gnt}, 8'h02);
    req = 3'b101;
    tick();
    chk("rr_turn2_gnt", {5'b0, gnt}, 8'h00);
    chk("rr_turn2_oe",  uio_oe,      8'h00);
    tick();
    chk("rr_gnt2",  {5'b0, gnt}, 8'h04);
    chk("rr_out2",  uio_out,     8'h33);
    tick();
    chk("rr_gnt2b", {5'b0, gnt}, 8'h04);
    req = 3'b001;
    tick();
    chk("rr_turn3_gnt", {5'b0, gnt}, 8'h00);
    chk("rr_turn3_oe",  uio_oe,      8'h00);
    tick();
    chk("rr_gnt0_again", {5'b0, gnt}, 8'h01);
    chk("rr_out0_again", uio_out,     8'h11);
    req = 3'b000;
    tick();
    chk("rr_idle_busy", {7'b0, busy}, 8'h00);

    // Abort: one-cycle pulse on req[1]
    req = 3'b010;
    tick();
    chk("abort_turn_busy", {7'b0, busy}, 8'h01);
    chk("abort_turn_gnt",  {5'b0, gnt},  8'h00);
    req = 3'b000;
    tick();
    chk("abort_idle_busy", {7'b0, busy}, 8'h00);
    chk("abort_idle_gnt",  {5'b0, gnt},  8'h00);
    chk("abort_idle_oe",   uio_oe,       8'h00);
    tick();
    chk("abort_after_gnt", {5'b0, gnt}, 8'h00);

    // Hold limit: requester 0 owns, requester 2 contends
    req   = 3'b001;
    dir   = 3'b001;
    wdata = 24'h000077;
    tick();
    chk("hold_turn", {5'b0, gnt}, 8'h00);
    tick();
    chk("hold_own1", {5'b0, gnt}, 8'h01);
    chk("hold_out",  uio_out,     8'h77);
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_own_2to4", {5'b0, gnt}, 8'h01);
    end
`ifdef ARB_HOLD_LIMIT_EN
    tick();
    chk("hold_forced_gnt", {5'b0, gnt}, 8'h00);
    chk("hold_forced_oe",  uio_oe,      8'h00);
    tick();
    chk("hold_gnt2",    {5'b0, gnt},    8'h04);
    chk("hold_oe2",     uio_oe,         8'h00);
    chk("hold_rvalid2", {7'b0, rvalid}, 8'h01);
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nohold_keep_gnt", {5'b0, gnt}, 8'h01);
      chk("nohold_keep_oe",  uio_oe,      8'hFF);
    end
`endif
    req = 3'b000;
    tick();
    chk("end_busy", {7'b0, busy}, 8'h00);
    chk("end_gnt",  {5'b0, gnt},  8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter that shares the bidirectional 8-bit uio pad bus among three internal requesters, such as the free-running counter, a debug readback and a config loader. It owns `uio_out`/`uio_oe` for the top level, inserts a one-cycle bus-turnaround between owners, and returns registered pad samples to input-direction owners. It sits between the datapath blocks and the top-level pad ports.

## Interface
- `HOLD_MAX`, default 15: max OWN cycles before a forced release, when contention exists (only with `ARB_HOLD_LIMIT_EN`); range 1..255.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req` in 3: per-requester bus request, level-sensitive.
- `dir` in 3: per-requester direction; 1 = drive pads, 0 = sample pads.
- `wdata` in 24: requester i's drive data on bits [8i+7:8i].
- `uio_in` in 8: pad input path.
- `gnt` out 3: one-hot grant, registered.
- `uio_out` out 8: pad output data, registered.
- `uio_oe` out 8: pad output enable, registered; all-ones or all-zeros only.
- `rdata` out 8: registered sample of `uio_in` for an input-direction owner.
- `rvalid` out 1: `rdata` updated this cycle.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, TURN, OWN. Internal registers:
  - `win[1:0]`: latched winner.
  - `wdir`: latched direction.
  - `last[1:0]`: previous winner, reset 2.
  - `hold[7:0]`: OWN cycle count.
- Arbitration: scan order starts at `last+1` mod 3; the first set `req` bit wins. `win`, `wdir` and `last` latch at the arbitration edge.
- IDLE: if any `req` is set, arbitrate and go to TURN. Otherwise stay in IDLE.
- TURN: `gnt`=0 and `uio_oe`=0 for exactly one cycle.
  - If `req[win]` is still 1, go to OWN.
  - Otherwise go to IDLE (abort; `last` keeps the aborted winner).
- OWN:
  - `gnt[win]`=1.
  - `uio_oe` = `wdir` ? 8'hFF : 8'h00.
  - If `wdir`=1, `uio_out` <= `wdata[8win+7:8win]` every cycle.
  - If `wdir`=0, `rdata` <= `uio_in` and `rvalid`=1 every cycle; `uio_out` holds its last value.
- Release: when `req[win]`=0 in OWN:
  - If any `req` bit is set, re-arbitrate and go to TURN.
  - Otherwise go to IDLE.
- `dir` changes while in OWN are ignored until the next grant.
- A requester may win consecutively only if no other request is pending at arbitration.
- Outside OWN: `gnt`=0, `uio_oe`=0, `rvalid`=0; `uio_out` and `rdata` hold.

## Timing
- Reset (sync, `rst_n`=0 at a rising edge) forces all of the following, overriding any state including mid-OWN:
  - `gnt`=0, `uio_oe`=0, `uio_out`=0, `rdata`=0, `rvalid`=0, `busy`=0.
  - state=IDLE, `last`=2, `hold`=0.
- Grant latency: `req` seen at edge E (IDLE) → TURN after E → `gnt` and `uio_oe` valid after E+1.
- Drive latency: `wdata` sampled at edge F appears on `uio_out` after F.
- Read latency: `uio_in` sampled at edge F appears on `rdata`, with `rvalid`=1, after F.
- Release latency: `req[win]` low at edge R → `gnt`=0 and `uio_oe`=0 after R.
- Owner-to-owner handover: at least one cycle with `uio_oe`=0 between owners. No cycle ever has two `gnt` bits set.
- Simultaneous release and new request at the same edge: handled as a release with re-arbitration. The released requester has the lowest priority.
- `req` dropping in TURN: abort to IDLE with no grant pulse.

## Configuration
- Macro: `ARB_HOLD_LIMIT_EN`.
- Defined:
  - `hold` clears on OWN entry and increments each OWN cycle, saturating.
  - When `hold` ≥ `HOLD_MAX-1` and another `req` bit is set, force release: re-arbitrate and go to TURN, even though `req[win]`=1.
  - With no contention, the owner keeps the bus indefinitely.
- Undefined:
  - No `hold` counter is built; `HOLD_MAX` is unused.
  - The owner keeps the bus until it drops `req`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=3'b111 → all outputs 0 and `busy`=0. After release of reset, the first grant goes to requester 0 (`gnt`=3'b001) two cycles after `req` is seen.
- Single drive owner: `req`=3'b010, `dir`=3'b010, `wdata[15:8]`=8'hA5 → `gnt`=3'b010, `uio_oe`=8'hFF, `uio_out`=8'hA5. Changing `wdata` to 8'h3C shows on `uio_out` one cycle later.
- Read owner: `req`=3'b100, `dir`=0, `uio_in`=8'h5A → `uio_oe`=0 and `rdata`=8'h5A with `rvalid`=1 each OWN cycle.
- Round-robin with all three requesting: each requester drops `req` after 2 OWN cycles → grant order 0, 1, 2, 0. Each handover has one cycle with `gnt`=0 and `uio_oe`=0.
- Abort: `req[1]` pulses for one cycle in IDLE → one TURN cycle, then IDLE; `gnt` never asserts.
- `ARB_HOLD_LIMIT_EN` with `HOLD_MAX`=4: requester 0 holds `req`, requester 2 requests → requester 0 is released after 4 OWN cycles and requester 2 is granted after one TURN cycle. Without the macro, requester 0 keeps the bus.
